run_ctrl: RTL and testbench

//  Host-side run controller for the basic processor. It sits at the other end of the DUT's

---
 rtl/run_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_run_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------------------------
// run_ctrl
//   Host-side run controller for the basic processor. Drives the DUT start pulse, waits for
//   its halt flag and measures the cycles each run takes. One go launches RUNS back-to-back
//   runs; each run is guarded by a MAX_CYC timeout. Per-run and accumulated counts are
//   reported, and the accumulated total saturates instead of wrapping.
//
// Parameters
//   CW         width of the per-run cycle counter (o_last_cycles)
//   TW         width of the accumulated total (o_total_cycles), saturating
//   RUNS       runs per go, 1..255
//   START_CYC  cycles o_dut_start is held high per run, >= 1
//   MAX_CYC    per-run timeout threshold in counted cycles, 1..2^CW-1
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_go            launch a sequence; honoured only in IDLE/DONE/TOUT
//   i_abort         return to IDLE from any state; beats i_go
//   i_dut_halt      halt flag from the DUT
//   o_dut_start     start pulse to the DUT
//   o_busy          high in START/BLANK/RUN
//   o_done          high in DONE, held until go/abort
//   o_timeout       high in TOUT, held until go/abort
//   o_run_idx       0-based index of the current/last run
//   o_last_cycles   count of the most recently completed or timed-out run
//   o_total_cycles  sum of completed run counts in this sequence
// ---------------------------------------------------------------------------------------------
module run_ctrl #(
    parameter int unsigned CW        = 16,
    parameter int unsigned TW        = 24,
    parameter int unsigned RUNS      = 3,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned MAX_CYC   = 16'hFFF0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_go,
    input  logic          i_abort,
    input  logic          i_dut_halt,
    output logic          o_dut_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_timeout,
    output logic [7:0]    o_run_idx,
    output logic [CW-1:0] o_last_cycles,
    output logic [TW-1:0] o_total_cycles
);

    localparam int unsigned    SW         = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int unsigned    SUMW       = ((CW > TW) ? CW : TW) + 1;
    localparam logic [SW-1:0]  START_LAST = SW'(START_CYC - 1);
    localparam logic [CW-1:0]  CYC_MAX    = CW'(MAX_CYC);
    localparam logic [7:0]     IDX_LAST   = 8'(RUNS - 1);
    localparam logic [SUMW-1:0] TOTAL_SAT = SUMW'({TW{1'b1}});

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBlank,
        StRun,
        StDone,
        StTout
    } state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [SW-1:0] r_start_cnt;
    logic [SW-1:0] w_start_cnt_next;
    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] w_cyc_cnt_next;
    logic [7:0]    r_run_idx;
    logic [7:0]    w_run_idx_next;
    logic [CW-1:0] r_last;
    logic [CW-1:0] w_last_next;
    logic [TW-1:0] r_total;
    logic [TW-1:0] w_total_next;
    logic          r_dut_start;
    logic          w_dut_start_next;
    logic          r_busy;
    logic          w_busy_next;
    logic          r_done;
    logic          w_done_next;
    logic          r_timeout;
    logic          w_timeout_next;

    logic            w_start_end;
    logic            w_last_run;
    logic            w_at_max;
    logic [SUMW-1:0] w_sum;
    logic [TW-1:0]   w_total_sat;

    assign w_start_end = (r_start_cnt == START_LAST);
    assign w_last_run  = (r_run_idx == IDX_LAST);
    assign w_at_max    = (r_cyc_cnt == CYC_MAX);

    // Sum is one bit wider than either operand so overflow is visible before clamping.
    assign w_sum       = SUMW'(r_total) + SUMW'(r_cyc_cnt);
    assign w_total_sat = (w_sum > TOTAL_SAT) ? {TW{1'b1}} : w_sum[TW-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone, StTout: begin
                    if (i_go) w_state_next = StStart;
                end
                StStart: begin
                    if (w_start_end) w_state_next = StBlank;
                end
                StBlank: w_state_next = StRun;
                StRun: begin
                    // A halt seen on the threshold cycle still counts as a completed run.
                    if (i_dut_halt) begin
                        w_state_next = w_last_run ? StDone : StStart;
                    end else if (w_at_max) begin
                        w_state_next = StTout;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Output and datapath next values. Flags are decoded from the next state so that every
    // output comes straight from a flop.
    always_comb begin
        w_start_cnt_next = r_start_cnt;
        w_cyc_cnt_next   = r_cyc_cnt;
        w_run_idx_next   = r_run_idx;
        w_last_next      = r_last;
        w_total_next     = r_total;
        w_dut_start_next = (w_state_next == StStart);
        w_busy_next      = (w_state_next == StStart) || (w_state_next == StBlank) ||
                           (w_state_next == StRun);
        w_done_next      = (w_state_next == StDone);
        w_timeout_next   = (w_state_next == StTout);

        if (!i_abort) begin
            unique case (r_state)
                StIdle, StDone, StTout: begin
                    if (i_go) begin
                        w_run_idx_next   = '0;
                        w_last_next      = '0;
                        w_total_next     = '0;
                        w_start_cnt_next = '0;
                        w_cyc_cnt_next   = '0;
                    end
                end
                StStart: begin
                    w_cyc_cnt_next = '0;
                    if (!w_start_end) w_start_cnt_next = r_start_cnt + SW'(1);
                end
                StBlank: w_cyc_cnt_next = CW'(1);
                StRun: begin
                    if (i_dut_halt) begin
                        w_last_next  = r_cyc_cnt;
                        w_total_next = w_total_sat;
                        if (!w_last_run) begin
                            w_run_idx_next   = r_run_idx + 8'd1;
                            w_start_cnt_next = '0;
                            w_cyc_cnt_next   = '0;
                        end
                    end else if (w_at_max) begin
                        // Timed-out run is reported but never added to the total.
                        w_last_next = r_cyc_cnt;
                    end else begin
                        w_cyc_cnt_next = r_cyc_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_cnt <= '0;
            r_cyc_cnt   <= '0;
            r_run_idx   <= '0;
            r_last      <= '0;
            r_total     <= '0;
            r_dut_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_start_cnt <= w_start_cnt_next;
            r_cyc_cnt   <= w_cyc_cnt_next;
            r_run_idx   <= w_run_idx_next;
            r_last      <= w_last_next;
            r_total     <= w_total_next;
            r_dut_start <= w_dut_start_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_timeout   <= w_timeout_next;
        end
    end

    assign o_dut_start    = r_dut_start;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_timeout      = r_timeout;
    assign o_run_idx      = r_run_idx;
    assign o_last_cycles  = r_last;
    assign o_total_cycles = r_total;

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_run_ctrl
//   Two controllers share clock and reset:
//     A: RUNS=3, START_CYC=3, MAX_CYC=20,  TW=24  (multi-run, timeout)
//     B: RUNS=1, START_CYC=2, MAX_CYC=280, TW=8   (single run, saturation)
//   A halt driver returns halt k cycles after the start pulse falls; a run with k above the
//   threshold never halts. Expected results come from a vector table and from a run-level
//   reference model for random sequences.
// ---------------------------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int unsigned A_RUNS = 3;
    localparam int unsigned A_SC   = 3;
    localparam int unsigned A_MAX  = 20;
    localparam int unsigned B_RUNS = 1;
    localparam int unsigned B_SC   = 2;
    localparam int unsigned B_MAX  = 280;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  go;
    logic [1:0]  abort;
    logic [1:0]  halt;
    logic [1:0]  dstart_w;
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  tout_w;
    logic [7:0]  idx_a;
    logic [7:0]  idx_b;
    logic [15:0] last_a;
    logic [15:0] last_b;
    logic [23:0] tot_a;
    logic [7:0]  tot_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .CW(16), .TW(24), .RUNS(A_RUNS), .START_CYC(A_SC), .MAX_CYC(A_MAX)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(go[0]), .i_abort(abort[0]), .i_dut_halt(halt[0]),
        .o_dut_start(dstart_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]),
        .o_timeout(tout_w[0]), .o_run_idx(idx_a), .o_last_cycles(last_a),
        .o_total_cycles(tot_a)
    );

    run_ctrl #(
        .CW(16), .TW(8), .RUNS(B_RUNS), .START_CYC(B_SC), .MAX_CYC(B_MAX)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(go[1]), .i_abort(abort[1]), .i_dut_halt(halt[1]),
        .o_dut_start(dstart_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]),
        .o_timeout(tout_w[1]), .o_run_idx(idx_b), .o_last_cycles(last_b),
        .o_total_cycles(tot_b)
    );

    typedef struct {
        int u;
        int k0;
        int k1;
        int k2;
        int e_last;
        int e_total;
        int e_idx;
        int e_done;
        int e_to;
    } vec_t;

    vec_t tbl [9];

    function automatic int runs_of(input int u);
        return (u == 0) ? int'(A_RUNS) : int'(B_RUNS);
    endfunction
    function automatic int sc_of(input int u);
        return (u == 0) ? int'(A_SC) : int'(B_SC);
    endfunction
    function automatic int max_of(input int u);
        return (u == 0) ? int'(A_MAX) : int'(B_MAX);
    endfunction
    function automatic longint sat_of(input int u);
        return (u == 0) ? 64'd16777215 : 64'd255;
    endfunction
    function automatic longint last_of(input int u);
        return (u == 0) ? longint'(last_a) : longint'(last_b);
    endfunction
    function automatic longint tot_of(input int u);
        return (u == 0) ? longint'(tot_a) : longint'(tot_b);
    endfunction
    function automatic longint idx_of(input int u);
        return (u == 0) ? longint'(idx_a) : longint'(idx_b);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go(input int u);
        go[u] = 1'b1;
        tick();
        go[u] = 1'b0;
    endtask

    // Called while the start pulse is expected high; returns in the first cycle it is low.
    task automatic wait_start_end(input int u, input int idx);
        int n = 0;
        while (dstart_w[u] && n < 50) begin
            n++;
            tick();
        end
        chk($sformatf("u%0d.start_len", u), n, sc_of(u));
        chk($sformatf("u%0d.run_idx", u), idx_of(u), idx);
    endtask

    task automatic do_halt(input int u, input int k);
        repeat (k) tick();
        halt[u] = 1'b1;
        tick();
        halt[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy_w[u] && n < 1000) begin
            n++;
            tick();
        end
        chk($sformatf("u%0d.idle_bound", u), busy_w[u], 0);
    endtask

    task automatic run_seq(input int u, input int ks [3]);
        bit stop = 1'b0;
        pulse_go(u);
        for (int i = 0; i < runs_of(u); i++) begin
            if (!stop) begin
                wait_start_end(u, i);
                if (ks[i] > max_of(u)) begin
                    wait_idle(u);
                    stop = 1'b1;
                end else begin
                    do_halt(u, ks[i]);
                end
            end
        end
    endtask

    // Run-level reference: each run either completes with its halt delay or times out at
    // the threshold; completed runs accumulate with clamping.
    task automatic model(input int u, input int ks [3], output longint e_last,
                         output longint e_total, output int e_idx, output int e_done,
                         output int e_to);
        e_last  = 0;
        e_total = 0;
        e_idx   = 0;
        e_done  = 0;
        e_to    = 0;
        for (int i = 0; i < runs_of(u); i++) begin
            e_idx = i;
            if (ks[i] > max_of(u)) begin
                e_last = max_of(u);
                e_to   = 1;
                break;
            end
            e_last  = ks[i];
            e_total = e_total + ks[i];
            if (e_total > sat_of(u)) e_total = sat_of(u);
            if (i == runs_of(u) - 1) e_done = 1;
        end
    endtask

    task automatic check_final(input string tag, input int u, input longint e_last,
                               input longint e_total, input int e_idx, input int e_done,
                               input int e_to);
        chk($sformatf("%s.last", tag), last_of(u), e_last);
        chk($sformatf("%s.total", tag), tot_of(u), e_total);
        chk($sformatf("%s.run_idx", tag), idx_of(u), e_idx);
        chk($sformatf("%s.done", tag), done_w[u], e_done);
        chk($sformatf("%s.timeout", tag), tout_w[u], e_to);
        chk($sformatf("%s.busy", tag), busy_w[u], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     ks [3];
        longint m_last;
        longint m_total;
        int     m_idx;
        int     m_done;
        int     m_to;
        int     u;

        tbl[0] = '{1, 10, 0, 0, 10, 10, 0, 1, 0};
        tbl[1] = '{0, 5, 7, 9, 9, 21, 2, 1, 0};
        tbl[2] = '{0, 99, 0, 0, 20, 0, 0, 0, 1};
        tbl[3] = '{0, 3, 99, 0, 20, 3, 1, 0, 1};
        tbl[4] = '{0, 20, 1, 20, 20, 41, 2, 1, 0};
        tbl[5] = '{0, 4, 21, 0, 20, 4, 1, 0, 1};
        tbl[6] = '{1, 260, 0, 0, 260, 255, 0, 1, 0};
        tbl[7] = '{1, 255, 0, 0, 255, 255, 0, 1, 0};
        tbl[8] = '{0, 1, 1, 1, 1, 3, 2, 1, 0};

        rst_n = 1'b1;
        go    = '0;
        abort = '0;
        halt  = '0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst.flags", {dstart_w, busy_w, done_w, tout_w}, 0);
        chk("rst.counts", {idx_a, idx_b, last_a, last_b, tot_a, tot_b}, 0);
        #19 rst_n = 1'b1;
        tick();
        chk("rst.idle", {dstart_w, busy_w}, 0);

        // Directed vectors
        for (int t = 0; t < 9; t++) begin
            ks = '{tbl[t].k0, tbl[t].k1, tbl[t].k2};
            run_seq(tbl[t].u, ks);
            check_final($sformatf("vec%0d", t), tbl[t].u, tbl[t].e_last, tbl[t].e_total,
                        tbl[t].e_idx, tbl[t].e_done, tbl[t].e_to);
        end

        // Halt held high through START and BLANK must not end the run early.
        halt[1] = 1'b1;
        pulse_go(1);
        wait_start_end(1, 0);
        tick();
        halt[1] = 1'b0;
        repeat (3) tick();
        halt[1] = 1'b1;
        tick();
        halt[1] = 1'b0;
        check_final("stale", 1, 4, 4, 0, 1, 0);

        // Abort and go together in DONE: abort wins, counts retained.
        ks = '{2, 3, 4};
        run_seq(0, ks);
        check_final("pre_abort", 0, 4, 9, 2, 1, 0);
        abort[0] = 1'b1;
        go[0]    = 1'b1;
        tick();
        abort[0] = 1'b0;
        go[0]    = 1'b0;
        chk("abgo.flags", {dstart_w[0], busy_w[0], done_w[0], tout_w[0]}, 0);
        chk("abgo.total", tot_a, 9);
        chk("abgo.last", last_a, 4);
        tick();
        chk("abgo.stay_idle", {dstart_w[0], busy_w[0]}, 0);

        // Go during RUN is ignored; abort mid-run drops the in-flight count.
        pulse_go(0);
        wait_start_end(0, 0);
        do_halt(0, 5);
        wait_start_end(0, 1);
        tick();
        tick();
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        chk("rungo.busy", busy_w[0], 1);
        chk("rungo.start", dstart_w[0], 0);
        chk("rungo.idx", idx_a, 1);
        chk("rungo.last", last_a, 5);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abrun.flags", {dstart_w[0], busy_w[0], done_w[0], tout_w[0]}, 0);
        chk("abrun.total", tot_a, 5);
        chk("abrun.idx", idx_a, 1);

        // Abort clears a sticky timeout.
        ks = '{99, 0, 0};
        run_seq(0, ks);
        chk("tout.flag", tout_w[0], 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abtout.flag", tout_w[0], 0);
        chk("abtout.last", last_a, 20);

        // Reset while the second start pulse is high.
        pulse_go(0);
        wait_start_end(0, 0);
        do_halt(0, 3);
        chk("mrst.pre_start", dstart_w[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.flags", {dstart_w[0], busy_w[0], done_w[0], tout_w[0]}, 0);
        chk("mrst.counts", {idx_a, last_a, tot_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst.idle", {dstart_w[0], busy_w[0]}, 0);

        // Random sequences against the reference model.
        for (int r = 0; r < 30; r++) begin
            u = int'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                ks[i] = (u == 0) ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 290));
            end
            run_seq(u, ks);
            model(u, ks, m_last, m_total, m_idx, m_done, m_to);
            check_final($sformatf("rnd%0d", r), u, m_last, m_total, m_idx, m_done, m_to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
